// File: rtl/alarm_bank.sv
// Multi-slot hour/minute alarm controller with ring auto-timeout and stop.
// Define ALARM_SNOOZE_EN to add the SNOOZED state and snooze target registers.

module alarm_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       en_toggle,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [5:0] hour,
  output logic [5:0] mn,
  output logic [5:0] hour_nxt,
  output logic [5:0] mn_nxt,
  output logic       en,
  output logic       hit
);
  always_comb begin
    hour_nxt = hour;
    mn_nxt   = mn;
    if (edit && inc_hr)  hour_nxt = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
    if (edit && inc_min) mn_nxt   = (mn == 6'd59) ? 6'd0 : mn + 6'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour <= '0;
      mn   <= '0;
      en   <= 1'b0;
    end else begin
      hour <= hour_nxt;
      mn   <= mn_nxt;
      en   <= en ^ (edit & en_toggle);
    end
  end

  assign hit = en && (hour == cur_hour) && (mn == cur_min);
endmodule

module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int SW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic [5:0]            cur_hour,
  input  logic [5:0]            cur_min,
  input  logic [5:0]            cur_sec,
  input  logic                  alarm_set,
  input  logic [SW-1:0]         sel,
  input  logic                  inc_hr,
  input  logic                  inc_min,
  input  logic                  en_toggle,
  input  logic                  stop,
  input  logic                  snooze,
  output logic [5:0]            sethour,
  output logic [5:0]            setmin,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic                  ring,
  output logic [SW-1:0]         ring_idx
);
`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
`else
  typedef enum logic [1:0] {IDLE, RINGING} state_t;
`endif

  logic [NUM_ALARMS-1:0][5:0] hr, mn, hr_n, mn_n;
  logic [NUM_ALARMS-1:0]      hit;
  logic                       sel_ok, any, match;
  logic [SW-1:0]              hidx, idx_nxt;
  logic [7:0]                 cnt, cnt_nxt;
  state_t                     state, state_nxt;

  assign sel_ok = ({1'b0, sel} < (SW+1)'(NUM_ALARMS));

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    alarm_slot u_slot (
      .clk(clk), .rst(rst),
      .edit(alarm_set && sel_ok && (sel == SW'(g))),
      .inc_hr(inc_hr), .inc_min(inc_min), .en_toggle(en_toggle),
      .cur_hour(cur_hour), .cur_min(cur_min),
      .hour(hr[g]), .mn(mn[g]), .hour_nxt(hr_n[g]), .mn_nxt(mn_n[g]),
      .en(alarm_en[g]), .hit(hit[g])
    );
  end

  // lowest matching index wins
  always_comb begin
    any  = 1'b0;
    hidx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (hit[i]) begin
        any  = 1'b1;
        hidx = SW'(i);
      end
  end

  assign match = tick_1hz && (cur_sec == 6'd0) && !alarm_set && any;

`ifdef ALARM_SNOOZE_EN
  logic [5:0] tgt_hr, tgt_min, tgt_hr_nxt, tgt_min_nxt, snz_hr, snz_min;
  logic [6:0] msum;
  logic       snz_hit;

  always_comb begin
    msum    = {1'b0, cur_min} + 7'(SNOOZE_MIN);
    snz_min = msum[5:0];
    snz_hr  = cur_hour;
    if (msum >= 7'd60) begin
      snz_min = 6'(msum - 7'd60);
      snz_hr  = (cur_hour >= 6'd23) ? 6'd0 : cur_hour + 6'd1;
    end
  end

  assign snz_hit = tick_1hz && (cur_sec == 6'd0) &&
                   (cur_hour == tgt_hr) && (cur_min == tgt_min);
`else
  logic unused_snz;
  assign unused_snz = snooze;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = ring_idx;
`ifdef ALARM_SNOOZE_EN
    tgt_hr_nxt  = tgt_hr;
    tgt_min_nxt = tgt_min;
`endif
    case (state)
      IDLE: if (match) begin
        state_nxt = RINGING;
        cnt_nxt   = '0;
        idx_nxt   = hidx;
      end
      RINGING: begin
        if (stop) state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          state_nxt   = SNOOZED;
          tgt_hr_nxt  = snz_hr;
          tgt_min_nxt = snz_min;
        end
`endif
        else if (tick_1hz) begin
          if (cnt == 8'(RING_SECS - 1)) state_nxt = IDLE;
          else                          cnt_nxt   = cnt + 8'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZED: begin
        if (stop) state_nxt = IDLE;
        else if (snz_hit) begin
          state_nxt = RINGING;
          cnt_nxt   = '0;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ring_idx <= '0;
      sethour  <= '0;
      setmin   <= '0;
`ifdef ALARM_SNOOZE_EN
      tgt_hr   <= '0;
      tgt_min  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ring_idx <= idx_nxt;
      // next-value view so an edit shows one clk after its pulse
      sethour  <= sel_ok ? hr_n[sel] : '0;
      setmin   <= sel_ok ? mn_n[sel] : '0;
`ifdef ALARM_SNOOZE_EN
      tgt_hr   <= tgt_hr_nxt;
      tgt_min  <= tgt_min_nxt;
`endif
    end
  end

  assign ring = (state == RINGING);
endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: edit, match priority, timeout, snooze, reset.
module tb_alarm_bank;
  localparam int NA = 5;
  localparam int SW = 3;

  logic          clk = 1'b0, rst = 1'b0, tick_1hz = 1'b0;
  logic [5:0]    cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic          alarm_set = 1'b0, inc_hr = 1'b0, inc_min = 1'b0;
  logic          en_toggle = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [5:0]    sethour, setmin;
  logic [NA-1:0] alarm_en;
  logic          ring;
  logic [SW-1:0] ring_idx;
  int total = 0, bad = 0;

  alarm_bank #(.NUM_ALARMS(NA), .RING_SECS(3), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .cur_hour(cur_hour),
    .cur_min(cur_min), .cur_sec(cur_sec), .alarm_set(alarm_set), .sel(sel),
    .inc_hr(inc_hr), .inc_min(inc_min), .en_toggle(en_toggle), .stop(stop),
    .snooze(snooze), .sethour(sethour), .setmin(setmin), .alarm_en(alarm_en),
    .ring(ring), .ring_idx(ring_idx)
  );

  always #5 clk = ~clk;

  task pulse(input bit h, input bit m, input bit e, input bit st, input bit sn);
    @(negedge clk);
    inc_hr = h; inc_min = m; en_toggle = e; stop = st; snooze = sn;
    @(negedge clk);
    inc_hr = 0; inc_min = 0; en_toggle = 0; stop = 0; snooze = 0;
  endtask

  task do_tick(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    cur_hour = h; cur_min = m; cur_sec = s; tick_1hz = 1;
    @(negedge clk);
    tick_1hz = 0;
  endtask

  task edit_mode(input bit on, input logic [SW-1:0] s);
    @(negedge clk);
    alarm_set = on; sel = s;
  endtask

  task test_reset;
    #12;
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL rst_ring got=%0b exp=0", ring); end
    total++; if (alarm_en !== 5'b0) begin bad++; $display("FAIL rst_en got=%b exp=00000", alarm_en); end
    total++; if (ring_idx !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", ring_idx); end
    total++; if (sethour !== 6'd0 || setmin !== 6'd0) begin bad++; $display("FAIL rst_set got=%0d:%0d exp=0:0", sethour, setmin); end
    @(negedge clk); rst = 1;
  endtask

  task test_set_ring;
    edit_mode(1, 3'd2);
    repeat (7) pulse(1, 0, 0, 0, 0);
    total++; if (sethour !== 6'd7) begin bad++; $display("FAIL set_hr got=%0d exp=7", sethour); end
    repeat (30) pulse(0, 1, 0, 0, 0);
    total++; if (setmin !== 6'd30) begin bad++; $display("FAIL set_min got=%0d exp=30", setmin); end
    pulse(0, 0, 1, 0, 0);
    total++; if (alarm_en !== 5'b00100) begin bad++; $display("FAIL set_en got=%b exp=00100", alarm_en); end
    edit_mode(0, 3'd2);
    do_tick(6'd7, 6'd30, 6'd1);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL sec_nz got=%0b exp=0", ring); end
    do_tick(6'd7, 6'd30, 6'd0);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL ring_on got=%0b exp=1", ring); end
    total++; if (ring_idx !== 3'd2) begin bad++; $display("FAIL ring_idx got=%0d exp=2", ring_idx); end
    pulse(0, 0, 0, 1, 0);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL stop got=%0b exp=0", ring); end
  endtask

  task test_wrap;
    edit_mode(1, 3'd0);
    repeat (23) pulse(1, 0, 0, 0, 0);
    repeat (59) pulse(0, 1, 0, 0, 0);
    total++; if (sethour !== 6'd23 || setmin !== 6'd59) begin bad++; $display("FAIL w_2359 got=%0d:%0d exp=23:59", sethour, setmin); end
    pulse(0, 1, 0, 0, 0);
    total++; if (sethour !== 6'd23 || setmin !== 6'd0) begin bad++; $display("FAIL w_min got=%0d:%0d exp=23:0", sethour, setmin); end
    pulse(1, 0, 0, 0, 0);
    total++; if (sethour !== 6'd0) begin bad++; $display("FAIL w_hr got=%0d exp=0", sethour); end
    pulse(1, 1, 0, 0, 0);
    total++; if (sethour !== 6'd1 || setmin !== 6'd1) begin bad++; $display("FAIL w_both got=%0d:%0d exp=1:1", sethour, setmin); end
  endtask

  task test_sel;
    edit_mode(1, 3'd2);
    @(negedge clk);
    total++; if (sethour !== 6'd7 || setmin !== 6'd30) begin bad++; $display("FAIL sel_view got=%0d:%0d exp=7:30", sethour, setmin); end
    edit_mode(1, 3'd5);
    @(negedge clk);
    total++; if (sethour !== 6'd0 || setmin !== 6'd0) begin bad++; $display("FAIL sel_oob got=%0d:%0d exp=0:0", sethour, setmin); end
    pulse(1, 1, 1, 0, 0);
    total++; if (alarm_en !== 5'b00100 || sethour !== 6'd0) begin bad++; $display("FAIL oob_edit got=%b/%0d exp=00100/0", alarm_en, sethour); end
  endtask

  task test_priority;
    edit_mode(1, 3'd1);
    repeat (6) pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    edit_mode(1, 3'd3);
    repeat (6) pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    total++; if (alarm_en !== 5'b01110) begin bad++; $display("FAIL pri_en got=%b exp=01110", alarm_en); end
    do_tick(6'd6, 6'd0, 6'd0);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL edit_block got=%0b exp=0", ring); end
    edit_mode(0, 3'd0);
    do_tick(6'd6, 6'd0, 6'd0);
    total++; if (ring !== 1'b1 || ring_idx !== 3'd1) begin bad++; $display("FAIL pri got=%0b/%0d exp=1/1", ring, ring_idx); end
    do_tick(6'd6, 6'd0, 6'd1);
    do_tick(6'd6, 6'd0, 6'd2);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL tmo_early got=%0b exp=1", ring); end
    do_tick(6'd6, 6'd0, 6'd3);
    total++; if (ring !== 1'b0 || ring_idx !== 3'd1) begin bad++; $display("FAIL tmo got=%0b/%0d exp=0/1", ring, ring_idx); end
  endtask

  task test_snooze;
    edit_mode(1, 3'd4);
    repeat (10) pulse(1, 0, 0, 0, 0);
    repeat (58) pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    edit_mode(0, 3'd4);
    do_tick(6'd10, 6'd58, 6'd0);
    total++; if (ring !== 1'b1 || ring_idx !== 3'd4) begin bad++; $display("FAIL snz_ring got=%0b/%0d exp=1/4", ring, ring_idx); end
    pulse(0, 0, 0, 0, 1);
`ifdef ALARM_SNOOZE_EN
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_off got=%0b exp=0", ring); end
    do_tick(6'd11, 6'd2, 6'd0);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_early got=%0b exp=0", ring); end
    do_tick(6'd11, 6'd3, 6'd0);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snz_wake got=%0b exp=1", ring); end
`else
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snz_ignored got=%0b exp=1", ring); end
`endif
    pulse(0, 0, 0, 1, 0);
    edit_mode(1, 3'd4);
    repeat (13) pulse(1, 0, 0, 0, 0);
    repeat (59) pulse(0, 1, 0, 0, 0);
    total++; if (sethour !== 6'd23 || setmin !== 6'd57) begin bad++; $display("FAIL snz_2357 got=%0d:%0d exp=23:57", sethour, setmin); end
    edit_mode(0, 3'd4);
    do_tick(6'd23, 6'd57, 6'd0);
    pulse(0, 0, 0, 0, 1);
`ifdef ALARM_SNOOZE_EN
    do_tick(6'd0, 6'd1, 6'd0);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snzw_early got=%0b exp=0", ring); end
    do_tick(6'd0, 6'd2, 6'd0);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snzw_wake got=%0b exp=1", ring); end
`else
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snzw_ignored got=%0b exp=1", ring); end
`endif
    pulse(0, 0, 0, 1, 0);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_stop got=%0b exp=0", ring); end
  endtask

  task test_stop_snooze;
    do_tick(6'd23, 6'd57, 6'd0);
    pulse(0, 0, 0, 1, 1);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL ss_off got=%0b exp=0", ring); end
    do_tick(6'd0, 6'd2, 6'd0);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL ss_idle got=%0b exp=0", ring); end
  endtask

  task test_rst_mid;
    do_tick(6'd23, 6'd57, 6'd0);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL rm_ring got=%0b exp=1", ring); end
    #2 rst = 0;
    #1;
    total++; if (ring !== 1'b0 || alarm_en !== 5'b0 || ring_idx !== 3'd0) begin bad++; $display("FAIL rm_clear got=%0b/%b/%0d exp=0/00000/0", ring, alarm_en, ring_idx); end
    @(negedge clk); rst = 1;
  endtask

  initial begin
    test_reset;
    test_set_ring;
    test_wrap;
    test_sel;
    test_priority;
    test_snooze;
    test_stop_snooze;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
